// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
// Holds the controller state encoding used by serial_subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ss_state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bundle for serial_subtractor.
// The master drives a request; the slave returns status and the result.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, borrow_out
    );
endinterface

// File: rtl/fs_cell.sv
// Combinational 1-bit full subtractor: d = x - y - c, bo = borrow out.
module fs_cell (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic d,
    output logic bo
);
    assign d  = x ^ y ^ c;
    assign bo = (~x & y) | (~(x ^ y) & c);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, through a single fs_cell with a registered borrow.
// One operation at a time; result and final borrow land on the DONE entry edge.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    ss_state_t        state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             brw;
    logic [CntW-1:0]  cnt;
    logic             d;
    logic             bo;

    fs_cell u_cell (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .c  (brw),
        .d  (d),
        .bo (bo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            a_sh           <= '0;
            b_sh           <= '0;
            res            <= '0;
            brw            <= 1'b0;
            cnt            <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.diff       <= '0;
            bus.borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh     <= bus.a;
                        b_sh     <= bus.b;
                        brw      <= bus.bin;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    res  <= {d, res[WIDTH-1:1]};
                    brw  <= bo;
                    cnt  <= cnt + 1'b1;
                    // Final bit goes straight into diff so the result is valid with done.
                    if (cnt == CntLast) begin
                        bus.diff       <= {d, res[WIDTH-1:1]};
                        bus.borrow_out <= bo;
                        bus.done       <= 1'b1;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor against an arithmetic reference.
module tb_serial_subtractor;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [W-1:0] last_diff = '0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {borrow, diff}: plain integer subtraction, borrow when the true result is negative.
    function automatic logic [W:0] ref_sub(input int a, input int b, input int bin);
        int r;
        r = a - b - bin;
        return {1'(r < 0), W'(r & ((1 << W) - 1))};
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input string tag);
        logic [W:0] exp;
        int         n;
        bit         held;
        exp = ref_sub(int'(a), int'(b), int'(bin));
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bin;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        held = 1'b1;
        n = 0;
        while (!bus.done && n < 20) begin
            if (bus.diff !== last_diff || !bus.busy) held = 1'b0;
            bus.a   = W'($urandom);
            bus.b   = W'($urandom);
            bus.bin = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, n, W);
        check({tag, "_held"}, 32'(held), 1);
        check({tag, "_diff"}, 32'(bus.diff), 32'(exp[W-1:0]));
        check({tag, "_bo"}, 32'(bus.borrow_out), 32'(exp[W]));
        check({tag, "_busy"}, 32'(bus.busy), 1);
        last_diff = exp[W-1:0];
        @(posedge clk); #1;
        check({tag, "_done_clr"}, 32'(bus.done), 0);
        check({tag, "_idle"}, 32'(bus.busy), 0);
    endtask

    initial begin
        int ndone;
        bit allbusy;
        int tdone[$];

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_diff", 32'(bus.diff), 0);
        check("rst_bo", 32'(bus.borrow_out), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run_op(8'h05, 8'h03, 1'b0, "t1");
        run_op(8'h03, 8'h05, 1'b0, "t2a");
        run_op(8'h00, 8'h00, 1'b1, "t2b");
        run_op(8'hFF, 8'h00, 1'b0, "t3a");
        run_op(8'h80, 8'h80, 1'b0, "t3b");

        // Start pulsed while busy must be ignored.
        bus.a = 8'h10; bus.b = 8'h01; bus.bin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        ndone = 0;
        allbusy = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            if (i == 3) begin
                bus.a = 8'h00; bus.b = 8'h01; bus.start = 1'b1;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.done) begin
                ndone++;
                check("t4_diff", 32'(bus.diff), 32'h0F);
                check("t4_bo", 32'(bus.borrow_out), 0);
            end
            if (i <= 8 && !bus.busy) allbusy = 1'b0;
        end
        check("t4_ndone", ndone, 1);
        check("t4_busy", 32'(allbusy), 1);
        last_diff = 8'h0F;

        // Reset mid-operation aborts silently.
        bus.a = 8'h33; bus.b = 8'h11; bus.bin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("t5_busy", 32'(bus.busy), 0);
        check("t5_done", 32'(bus.done), 0);
        check("t5_diff", 32'(bus.diff), 0);
        check("t5_bo", 32'(bus.borrow_out), 0);
        @(posedge clk); #1 rst = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        check("t5_nodone", ndone, 0);
        last_diff = '0;
        run_op(8'h09, 8'h04, 1'b0, "t5b");

        // Start held high: back-to-back ops every WIDTH+2 cycles.
        bus.a = 8'h20; bus.b = 8'h01; bus.bin = 1'b0; bus.start = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                tdone.push_back(i);
                check("t6_diff", 32'(bus.diff), 32'h1F);
            end
        end
        bus.start = 1'b0;
        check("t6_ndone", tdone.size(), 3);
        for (int k = 1; k < tdone.size(); k++) check("t6_period", tdone[k] - tdone[k-1], W + 2);
        @(posedge clk); #1;
        check("t6_idle", 32'(bus.busy), 0);
        last_diff = 8'h1F;

        for (int k = 0; k < 1000; k++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), "rnd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
